// File: rtl/seg_scan_if.sv
// Load port and display drive lines of the 7-segment scan controller.
interface seg_scan_if #(
  parameter int unsigned NUM_DIGITS = 4
);
  localparam int unsigned IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  logic                    loadValid;
  logic                    loadReady;
  logic [4*NUM_DIGITS-1:0] loadData;
  logic [NUM_DIGITS-1:0]   dpIn;
  logic [NUM_DIGITS-1:0]   digitEn;
  logic                    zeroBlank;
  logic [3:0]              hexOut;
  logic [NUM_DIGITS-1:0]   anodeOut;
  logic                    dpOut;
  logic [IDX_W-1:0]        digitIdx;
  logic                    frameDone;

  modport master (
    output loadValid, loadData, dpIn, digitEn, zeroBlank,
    input  loadReady, hexOut, anodeOut, dpOut, digitIdx, frameDone
  );

  modport slave (
    input  loadValid, loadData, dpIn, digitEn, zeroBlank,
    output loadReady, hexOut, anodeOut, dpOut, digitIdx, frameDone
  );
endinterface

// File: rtl/seg_scan_controller.sv
// Time-multiplexed scan controller for a common-anode 7-segment display with
// double-buffered, frame-aligned value loads and per-slot anti-ghosting guard time.
module seg_scan_controller #(
  parameter int unsigned NUM_DIGITS   = 4,
  parameter int unsigned REFRESH_DIV  = 100000,
  parameter int unsigned BLANK_CYCLES = 4
) (
  input logic       clk,
  input logic       reset,
  seg_scan_if.slave bus
);
  localparam int unsigned IDX_W  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int unsigned CNT_W  = $clog2(REFRESH_DIV);
  localparam int unsigned DATA_W = 4 * NUM_DIGITS;

  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(REFRESH_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_BLANK = CNT_W'(BLANK_CYCLES);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_DIGITS - 1);

  typedef enum logic {GUARD, DRIVE} slot_t;

  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [DATA_W-1:0]     disp_q, disp_d;
  logic [DATA_W-1:0]     pend_q, pend_d;
  logic                  pend_vld_q, pend_vld_d;
  logic                  ready_q;
  logic [3:0]            hex_q, hex_d;
  logic [NUM_DIGITS-1:0] anode_q, anode_d;
  logic                  dp_q, dp_d;
  logic                  frame_q, frame_d;
  slot_t                 slot_d;
  logic                  accept, commit;
  logic                  en_bit, dp_bit, lead_zero, lit;

  // Next-state and next-output logic; outputs are computed from the next slot
  // position so they line up with digitIdx without a cycle of skew.
  always_comb begin
    cnt_d      = (cnt_q == CNT_LAST) ? '0 : cnt_q + 1'b1;
    idx_d      = idx_q;
    if (cnt_q == CNT_LAST) begin
      idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
    end

    commit     = frame_q && pend_vld_q;
    accept     = bus.loadValid && ready_q;
    disp_d     = commit ? pend_q : disp_q;
    pend_d     = accept ? bus.loadData : pend_q;
    pend_vld_d = accept || (pend_vld_q && !commit);

    slot_d     = (cnt_d < CNT_BLANK) ? GUARD : DRIVE;
    hex_d      = 4'h0;
    en_bit     = 1'b0;
    dp_bit     = 1'b0;
    lead_zero  = bus.zeroBlank && (idx_d != '0);
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (IDX_W'(i) == idx_d) begin
        hex_d  = disp_d[4*i +: 4];
        en_bit = bus.digitEn[i];
        dp_bit = bus.dpIn[i];
      end
      if ((IDX_W'(i) >= idx_d) && (disp_d[4*i +: 4] != 4'h0)) begin
        lead_zero = 1'b0;
      end
    end

    lit     = (slot_d == DRIVE) && en_bit && !lead_zero;
    anode_d = '1;
    dp_d    = 1'b1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (lit && (IDX_W'(i) == idx_d)) begin
        anode_d[i] = 1'b0;
      end
    end
    if (lit) begin
      dp_d = ~dp_bit;
    end

    frame_d = (cnt_d == CNT_LAST) && (idx_d == IDX_LAST);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q      <= '0;
      idx_q      <= '0;
      disp_q     <= '0;
      pend_q     <= '0;
      pend_vld_q <= 1'b0;
      ready_q    <= 1'b1;
      hex_q      <= 4'h0;
      anode_q    <= '1;
      dp_q       <= 1'b1;
      frame_q    <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      disp_q     <= disp_d;
      pend_q     <= pend_d;
      pend_vld_q <= pend_vld_d;
      ready_q    <= !pend_vld_d;
      hex_q      <= hex_d;
      anode_q    <= anode_d;
      dp_q       <= dp_d;
      frame_q    <= frame_d;
    end
  end

  assign bus.loadReady = ready_q;
  assign bus.hexOut    = hex_q;
  assign bus.anodeOut  = anode_q;
  assign bus.dpOut     = dp_q;
  assign bus.digitIdx  = idx_q;
  assign bus.frameDone = frame_q;
endmodule
